// File: rtl/uart_rx_868.sv
// uart_rx_868: 8N1 serial receiver with mid-bit sampling.
//
// The asynchronous rx line is passed through a two-flop synchroniser. The
// start bit is detected and confirmed at its midpoint. Every later bit is
// then sampled one full bit period after the previous sample. Good bytes are
// delivered on rx_data with a one-cycle rx_valid strobe. A low stop bit
// gives a one-cycle frame_err strobe. The receiver then parks in BREAK until
// the line returns high.
//
// Ports:
//   clk        - single clock, all logic on the rising edge
//   a_reset_n  - asynchronous active-low reset
//   rx         - serial input, idle high, asynchronous to clk
//   rx_data    - last good byte, held until the next good frame
//   rx_valid   - one-cycle pulse when rx_data is updated
//   frame_err  - one-cycle pulse when a sampled stop bit is 0
//   busy       - high whenever the receiver is not IDLE
module uart_rx_868 #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 a_reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t                 state, state_n;
  logic                   rx_s1, rx_s;
  logic [1:0]             settle;
  logic                   armed;
  logic [CW-1:0]          cnt, cnt_n;
  logic [BW-1:0]          bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0]   sh, sh_n;
  logic [DATA_BITS-1:0]   data_n;
  logic                   valid_n, ferr_n;

  // Synchroniser plus start qualification. The synchroniser flops come out
  // of reset at 1, so for two clocks rx_s does not yet reflect the pin.
  // settle covers that window. armed goes high only after rx_s has really
  // been seen high. A line that is still low when reset is released (for
  // example mid-frame) therefore cannot start a bogus frame. The receiver
  // waits for the next genuine falling edge instead.
  // NOTE: state registers use non-blocking assignments so that every flop
  // samples pre-edge values, which is exactly what hardware does.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      rx_s1  <= 1'b1;
      rx_s   <= 1'b1;
      settle <= 2'b00;
      armed  <= 1'b0;
    end else begin
      rx_s1  <= rx;
      rx_s   <= rx_s1;
      settle <= {settle[0], 1'b1};
      armed  <= armed | (rx_s & settle[1]);
    end
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      sh        <= sh_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
    end
  end

  // Next-state logic. The counter free-runs and is cleared on every state
  // entry and on every sample point.
  // NOTE: every signal gets a default before the case statement. No path
  // can leave a signal unassigned, so no latch is inferred.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    sh_n      = sh;
    data_n    = rx_data;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (armed && !rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;  // glitch shorter than half a bit
          end
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh[DATA_BITS-1:1]};  // LSB arrives first
          if (bit_idx == LAST_BIT) state_n = STOP;
          else                     bit_idx_n = bit_idx + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n  = sh;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
